// File: rtl/writeback.sv
// Writeback stage: buffers EX_WB results in a small FIFO, drains them to the
// register-file write port with a valid/ack handshake, and exposes the head as a bypass.
module writeback #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W+ADDR_W+1:0] EX_WB,
  output logic                     wb_stall,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic                     rf_ack,
  output logic                     fwd_valid,
  output logic [ADDR_W-1:0]        fwd_rd,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [CNT_W-1:0]         retired_count
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W   = PTR_W + 1;
  localparam int unsigned ENT_W   = 1 + ADDR_W + DATA_W;
  localparam int unsigned VLD_BIT = DATA_W + ADDR_W + 1;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;

  logic              head_rw;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_res;
  logic              empty;
  logic              writing;
  logic              push;
  logic              pop;

  // Head decode and handshake; stall depends on registered occupancy only.
  always_comb begin
    {head_rw, head_rd, head_res} = mem[rd_ptr];
    empty     = (occ == '0);
    wb_stall  = (occ == OCC_W'(DEPTH));
    writing   = !empty && head_rw && (head_rd != '0);
    rf_we     = writing;
    rf_waddr  = writing ? head_rd  : '0;
    rf_wdata  = writing ? head_res : '0;
    fwd_valid = writing;
    fwd_rd    = rf_waddr;
    fwd_data  = rf_wdata;
    push      = EX_WB[VLD_BIT] && !wb_stall;
    pop       = writing ? rf_ack : !empty;
  end

  // Entry storage needs no reset: occupancy gates every use of it.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= EX_WB[ENT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      retired_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        retired_count <= retired_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_writeback;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 4;

  logic              clock;
  logic              reset;
  logic [70:0]       ex_wb;
  logic              wb_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ack;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retired_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] res;
  } ent_t;

  ent_t              q[$];
  int                mcnt;
  logic [ADDR_W-1:0] obs[$];

  writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .EX_WB(ex_wb), .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ack(rf_ack),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retired_count(retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model view of the pending queue
  function automatic logic m_writing();
    return (q.size() > 0) && q[0].rw && (q[0].rd != '0);
  endfunction
  function automatic logic m_stall();
    return q.size() == DEPTH;
  endfunction
  function automatic logic [ADDR_W-1:0] m_addr();
    return m_writing() ? q[0].rd : '0;
  endfunction
  function automatic logic [DATA_W-1:0] m_data();
    return m_writing() ? q[0].res : '0;
  endfunction
  function automatic logic [CNT_W-1:0] m_cnt();
    return CNT_W'(mcnt);
  endfunction

  function automatic logic [70:0] mk(input logic rw, input logic [ADDR_W-1:0] rd,
                                     input logic [DATA_W-1:0] res);
    return {1'b1, rw, rd, res};
  endfunction

  // One clock cycle: advance the model with the current inputs, log accepted writes.
  task automatic tick();
    logic full, wr, pop;
    ent_t e;
    full = m_stall();
    wr   = m_writing();
    pop  = (q.size() > 0) && (!wr || rf_ack);
    if (rf_we === 1'b1 && rf_ack === 1'b1) obs.push_back(rf_waddr);
    if (pop) begin
      void'(q.pop_front());
      mcnt++;
    end
    if (ex_wb[70] && !full) begin
      e.rw = ex_wb[69]; e.rd = ex_wb[68:64]; e.res = ex_wb[63:0];
      q.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0; ex_wb = '0; rf_ack = 1'b0;
    @(posedge clock); @(negedge clock);
    q.delete(); obs.delete(); mcnt = 0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; rf_ack = 1'b0;
    ex_wb = 71'h7F_FFFF_FFFF_FFFF_FFFF;
    repeat (3) begin @(posedge clock); @(negedge clock); end
    q.delete(); obs.delete(); mcnt = 0;
    checks++;
    if ({wb_stall, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, retired_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b we=%b addr=%0d data=%h fv=%b frd=%0d fd=%h cnt=%0d, all zero required",
               wb_stall, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, retired_count);
    end
    reset = 1'b1;
    tick();
    ex_wb = '0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL reset_first_push: got we=%b addr=%0d data=%h, required 1/31/ffffffffffffffff", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || retired_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold_no_ack: got we=%b addr=%0d cnt=%0d, required 1/31/0", rf_we, rf_waddr, retired_count);
    end
    rf_ack = 1'b1;
    tick();
    checks++;
    if (rf_we !== 1'b0 || retired_count !== 4'd1) begin
      errors++;
      $display("FAIL reset_drain: got we=%b cnt=%0d, required 0/1", rf_we, retired_count);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    rf_ack = 1'b1;
    ex_wb = mk(1'b1, 5'd5, 64'h1234);
    tick();
    ex_wb = '0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h1234 ||
        fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 64'h1234) begin
      errors++;
      $display("FAIL single_write: got we=%b addr=%0d data=%h fv=%b frd=%0d fd=%h, required 1/5/1234 mirrored",
               rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || fwd_data !== 64'h0 || retired_count !== 4'd1) begin
      errors++;
      $display("FAIL single_after: got we=%b fv=%b fd=%h cnt=%0d, required 0/0/0/1", rf_we, fwd_valid, fwd_data, retired_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rf_ack = 1'b0;
    ex_wb = mk(1'b1, 5'd3, 64'h33); tick();
    ex_wb = mk(1'b1, 5'd4, 64'h44); tick();
    checks++;
    if (wb_stall !== 1'b1) begin
      errors++;
      $display("FAIL bp_full_stall: got %b, required 1", wb_stall);
    end
    ex_wb = mk(1'b1, 5'd7, 64'h77); tick();
    checks++;
    if (wb_stall !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 64'h33) begin
      errors++;
      $display("FAIL bp_hold: got stall=%b addr=%0d data=%h, required 1/3/33", wb_stall, rf_waddr, rf_wdata);
    end
    rf_ack = 1'b1; tick();
    checks++;
    if (wb_stall !== 1'b0 || rf_waddr !== 5'd4 || q.size() != 1) begin
      errors++;
      $display("FAIL bp_pop_no_push: got stall=%b addr=%0d, required 0/4", wb_stall, rf_waddr);
    end
    rf_ack = 1'b0; tick();
    ex_wb = '0;
    checks++;
    if (wb_stall !== 1'b1) begin
      errors++;
      $display("FAIL bp_third_accept: got stall=%b, required 1", wb_stall);
    end
    rf_ack = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs.size() != 3 || obs[0] !== 5'd3 || obs[1] !== 5'd4 || obs[2] !== 5'd7) begin
      errors++;
      $display("FAIL bp_order: got %0d writes %p, required 3,4,7", obs.size(), obs);
    end
    checks++;
    if (retired_count !== 4'd3 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: got cnt=%0d we=%b, required 3/0", retired_count, rf_we);
    end
  endtask

  task automatic test_suppress();
    int we_seen = 0;
    do_reset();
    rf_ack = 1'b0;
    ex_wb = mk(1'b0, 5'd9, 64'h99); tick();
    if (rf_we !== 1'b0) we_seen++;
    ex_wb = mk(1'b1, 5'd0, 64'hAA); tick();
    if (rf_we !== 1'b0) we_seen++;
    ex_wb = '0; tick();
    if (rf_we !== 1'b0) we_seen++;
    checks++;
    if (we_seen != 0 || fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL suppress_we: got %0d cycles with rf_we set, required 0", we_seen);
    end
    checks++;
    if (retired_count !== 4'd2 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL suppress_count: got cnt=%0d stall=%b, required 2/0", retired_count, wb_stall);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rf_ack = 1'b1;
    ex_wb = mk(1'b1, 5'd1, 64'h1); tick();
    ex_wb = '0; tick();
    rf_ack = 1'b0;
    ex_wb = mk(1'b1, 5'd10, 64'hA); tick();
    ex_wb = mk(1'b1, 5'd11, 64'hB); tick();
    ex_wb = '0;
    checks++;
    if (wb_stall !== 1'b1 || retired_count !== 4'd1) begin
      errors++;
      $display("FAIL mid_setup: got stall=%b cnt=%0d, required 1/1", wb_stall, retired_count);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (wb_stall !== 1'b0 || rf_we !== 1'b0 || retired_count !== 4'd0) begin
      errors++;
      $display("FAIL mid_async: got stall=%b we=%b cnt=%0d, required 0/0/0", wb_stall, rf_we, retired_count);
    end
    @(negedge clock);
    q.delete(); obs.delete(); mcnt = 0;
    reset = 1'b1; rf_ack = 1'b1;
    repeat (4) tick();
    checks++;
    if (obs.size() != 0 || rf_we !== 1'b0 || retired_count !== 4'd0) begin
      errors++;
      $display("FAIL mid_discard: got %0d writes we=%b cnt=%0d, required 0/0/0", obs.size(), rf_we, retired_count);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    rf_ack = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ex_wb = mk(i[0], 5'(i + 1), 64'(i));
      tick();
    end
    ex_wb = '0;
    repeat (3) tick();
    checks++;
    if (retired_count !== 4'd1 || mcnt != 17) begin
      errors++;
      $display("FAIL counter_wrap: got %0d (model retired %0d), required 1", retired_count, mcnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!(ex_wb[70] && wb_stall)) begin
        if ($urandom_range(3) != 0)
          ex_wb = mk(1'($urandom_range(1)), 5'($urandom_range(31) & (($urandom_range(5) == 0) ? 0 : 31)),
                     {$urandom, $urandom});
        else
          ex_wb = {1'b0, 70'($urandom)};
      end
      rf_ack = ($urandom_range(2) != 0);
      tick();
      checks++;
      if (wb_stall !== m_stall()) begin
        errors++; $display("FAIL rand_stall c%0d: got %b required %b", i, wb_stall, m_stall());
      end
      checks++;
      if (rf_we !== m_writing() || fwd_valid !== m_writing()) begin
        errors++; $display("FAIL rand_we c%0d: got we=%b fv=%b required %b", i, rf_we, fwd_valid, m_writing());
      end
      checks++;
      if (rf_waddr !== m_addr() || fwd_rd !== m_addr()) begin
        errors++; $display("FAIL rand_addr c%0d: got %0d/%0d required %0d", i, rf_waddr, fwd_rd, m_addr());
      end
      checks++;
      if (rf_wdata !== m_data() || fwd_data !== m_data()) begin
        errors++; $display("FAIL rand_data c%0d: got %h/%h required %h", i, rf_wdata, fwd_data, m_data());
      end
      checks++;
      if (retired_count !== m_cnt()) begin
        errors++; $display("FAIL rand_count c%0d: got %0d required %0d", i, retired_count, m_cnt());
      end
    end
  endtask

  initial begin
    reset = 1'b0; ex_wb = '0; rf_ack = 1'b0; mcnt = 0;
    test_reset();
    test_single_write();
    test_backpressure();
    test_suppress();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
